xgri_mc: RTL and testbench
==========================

XGRI_MC -- requirements
Module: xgri_mc

Interface
REQ-001 SHALL have parameter NCH, default 2, number of channels (1..7).
REQ-002 SHALL have parameter DW, default 16, data and CPU word width (>=16, >=AW).
REQ-003 SHALL have parameter DEPTH, default 16, per-channel FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter AW, default 13, channel address register width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ri_en  in  1  register access strobe
- ri_wren  in  1  write qualifier
- ri_ren  in  1  read qualifier (informational; reads occur on ri_en)
- ri_addr  in  5  register index
- from_cpu  in  DW  write data
- to_cpu  out  DW  registered read data
- ch_full  out  NCH  per-channel FIFO full
- ch_pop  in  NCH  per-channel pop from consumer
- ch_data  out  NCH*DW  per-channel FIFO head word (channel c at [c*DW +: DW])
- ch_addr  out  NCH*AW  per-channel address register
- irq  out  1  drain interrupt

Function
REQ-007 Register map SHALL be:
- 0 STATUS (RO): bit c = empty[c], bit 8+c = full[c]
- 1 IRQ: bits[6:0] pending (write-1-to-clear), bits[14:8] enable (R/W)
- 2 FLUSH (WO, reads 0): writing 1 to bit c empties channel c
- 3 reserved, reads 0
- 4+4c+0 ADDR[c] (R/W, AW bits); +1 STEP[c] (R/W, AW bits); +2 DATA[c] (write pushes, reads 0); +3 LEVEL[c] (RO, $clog2(DEPTH)+1 bits).
- Indices of absent channels read 0 and ignore writes.
REQ-008 to_cpu SHALL update one cycle after ri_en with the addressed register value and hold otherwise; unused upper bits read 0.
REQ-009 A write to DATA[c] while full[c] SHALL be dropped with FIFO contents and level unchanged.
REQ-010 ch_pop[c] while empty[c] SHALL be ignored.
REQ-011 Simultaneous push and pop on a full channel SHALL perform both, leaving level unchanged.
REQ-012 Simultaneous push and pop on an empty channel SHALL accept the push and ignore the pop.
REQ-013 ch_data slice c SHALL show the head entry combinationally (show-ahead) and be valid only while empty[c]=0.
REQ-014 A drain event on channel c SHALL be a pop that takes level[c] from 1 to 0 with no flush of c in the same cycle.
REQ-015 On a drain event, ADDR[c] SHALL increase by STEP[c] modulo 2^AW and pending[c] SHALL be set, both visible the next cycle.
REQ-016 A flush SHALL zero level[c] without a drain event, address change or pending set; a flush coinciding with a push SHALL discard the push.
REQ-017 A CPU write to ADDR[c] coinciding with a drain event SHALL take the CPU value; pending[c] SHALL still be set.
REQ-018 A W1C coinciding with a pending set on the same bit SHALL leave the bit set.
REQ-019 irq SHALL equal the OR of (pending AND enable) from registered state.

Reset
REQ-020 On rst: all FIFOs empty, ADDR=0, STEP=1, pending=0, enable=0, to_cpu=0, irq=0, ch_full=0.
REQ-021 rst asserted mid-burst SHALL discard queued data immediately, without generating a drain event.

Structure
REQ-022 Package xgri_pkg SHALL hold register index constants (STATUS, IRQ, FLUSH, channel base/stride/offsets) and STATUS/IRQ bit positions.
REQ-023 A sub-module queue_p (parameters DW, DEPTH; ports push, pop, flush, din, dout, full, empty, level) SHALL be instantiated once per channel via generate.

Verification
REQ-024 Push 3 words to DATA[0] with STEP[0]=4 and ADDR[0]=0x100, then pop 3 -> ch_data order preserved, ADDR[0]=0x104 one cycle after last pop, pending[0]=1.
REQ-025 Push DEPTH+1 words to channel 1 -> ch_full[1]=1 after DEPTH pushes, LEVEL[1]=DEPTH, extra word absent on drain.
REQ-026 Enable bit 0, drain channel 0 -> irq=1; W1C bit 0 -> irq=0 next cycle; W1C coinciding with a new drain -> pending stays 1.
REQ-027 Fill channel 0 with 5 words, write FLUSH=0x1 -> LEVEL[0]=0, ADDR[0] unchanged, pending[0]=0.
REQ-028 ADDR[0]=(2^AW)-2, STEP=4, drain -> ADDR[0]=2; CPU writes ADDR[0]=0x55 on the drain cycle -> ADDR[0]=0x55.
REQ-029 Assert rst with channel 1 holding 4 words -> all outputs at reset values, STATUS shows all empty.

Source files
------------

// File: rtl/xgri_pkg.sv
// Register map constants and bit positions shared by the multi-channel
// FIFO/address engine and its per-channel queue.
package xgri_pkg;
   localparam int MAX_CH = 7;

   localparam logic [4:0] REG_STATUS = 5'd0;
   localparam logic [4:0] REG_IRQ    = 5'd1;
   localparam logic [4:0] REG_FLUSH  = 5'd2;
   localparam logic [4:0] REG_RSVD   = 5'd3;
   localparam logic [4:0] CH_BASE    = 5'd4;
   localparam int         CH_STRIDE  = 4;

   typedef enum logic [1:0] {
      OFF_ADDR  = 2'd0,
      OFF_STEP  = 2'd1,
      OFF_DATA  = 2'd2,
      OFF_LEVEL = 2'd3
   } ch_off_e;

   localparam int STAT_EMPTY_LSB = 0;
   localparam int STAT_FULL_LSB  = 8;
   localparam int IRQ_PEND_LSB   = 0;
   localparam int IRQ_EN_LSB     = 8;

   // Register index of a given channel register.
   function automatic logic [4:0] ch_reg(input int c, input ch_off_e off);
      return 5'(int'(CH_BASE) + CH_STRIDE * c + int'(off));
   endfunction
endpackage

// File: rtl/xgri_mc_queue.sv
// Show-ahead FIFO for one channel with flush; a push on a full queue is
// accepted only when a pop frees a slot in the same cycle.
module queue_p #(
   parameter int DW    = 16,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [LW-1:0] r_cnt;
   logic          w_pop;
   logic          w_push;

   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop) && !flush;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PW'(1);
         if (w_pop)  r_rd <= r_rd + PW'(1);
         r_cnt <= r_cnt + LW'(w_push) - LW'(w_pop);
      end
   end

   assign empty = (r_cnt == '0);
   assign full  = (r_cnt == LW'(DEPTH));
   assign dout  = r_mem[r_rd];
   assign level = r_cnt;
endmodule

// File: rtl/xgri_mc.sv
// Multi-channel CPU-fed FIFOs; each channel carries an address that advances
// by its step whenever the consumer drains the channel, raising an interrupt.
module xgri_mc
   import xgri_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int DW    = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 13
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              ri_en,
   input  logic              ri_wren,
   input  logic              ri_ren,
   input  logic [4:0]        ri_addr,
   input  logic [DW-1:0]     from_cpu,
   output logic [DW-1:0]     to_cpu,
   output logic [NCH-1:0]    ch_full,
   input  logic [NCH-1:0]    ch_pop,
   output logic [NCH*DW-1:0] ch_data,
   output logic [NCH*AW-1:0] ch_addr,
   output logic              irq
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [AW-1:0]  r_addr [NCH];
   logic [AW-1:0]  r_step [NCH];
   logic [NCH-1:0] r_pend;
   logic [NCH-1:0] r_en;

   logic           w_wr;
   logic           w_irq_wr;
   logic [NCH-1:0] w_w1c;
   logic [NCH-1:0] w_push;
   logic [NCH-1:0] w_flush;
   logic [NCH-1:0] w_drain;
   logic [NCH-1:0] w_full;
   logic [NCH-1:0] w_empty;
   logic [DW-1:0]  w_dout  [NCH];
   logic [LW-1:0]  w_level [NCH];
   logic [DW-1:0]  w_rdata;
   logic           w_unused;

   assign w_unused = ri_ren;
   assign w_wr     = ri_en && ri_wren;
   assign w_irq_wr = w_wr && (ri_addr == REG_IRQ);
   assign w_w1c    = w_irq_wr ? from_cpu[IRQ_PEND_LSB +: NCH] : '0;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign w_push[c]  = w_wr && (ri_addr == ch_reg(c, OFF_DATA));
      assign w_flush[c] = w_wr && (ri_addr == REG_FLUSH) && from_cpu[c];

      queue_p #(.DW(DW), .DEPTH(DEPTH)) u_q (
         .clk   (clk_sys),
         .rst   (rst),
         .push  (w_push[c]),
         .pop   (ch_pop[c]),
         .flush (w_flush[c]),
         .din   (from_cpu),
         .dout  (w_dout[c]),
         .full  (w_full[c]),
         .empty (w_empty[c]),
         .level (w_level[c])
      );

      // A same-cycle push keeps the level at 1, so it is not a drain.
      assign w_drain[c] = ch_pop[c] && (w_level[c] == LW'(1)) && !w_push[c] && !w_flush[c];
      assign ch_data[c*DW +: DW] = w_dout[c];
      assign ch_addr[c*AW +: AW] = r_addr[c];
   end

   assign ch_full = w_full;
   assign irq     = |(r_pend & r_en);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_addr[c] <= '0;
            r_step[c] <= AW'(1);
         end
         r_pend <= '0;
         r_en   <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (w_wr && (ri_addr == ch_reg(c, OFF_ADDR)))
               r_addr[c] <= from_cpu[AW-1:0];
            else if (w_drain[c])
               r_addr[c] <= r_addr[c] + r_step[c];
            if (w_wr && (ri_addr == ch_reg(c, OFF_STEP)))
               r_step[c] <= from_cpu[AW-1:0];
         end
         // A new drain wins over a W1C on the same bit.
         r_pend <= (r_pend & ~w_w1c) | w_drain;
         if (w_irq_wr) r_en <= from_cpu[IRQ_EN_LSB +: NCH];
      end
   end

   always_comb begin
      w_rdata = '0;
      if (ri_addr == REG_STATUS) begin
         for (int c = 0; c < NCH; c++) begin
            w_rdata[STAT_EMPTY_LSB + c] = w_empty[c];
            w_rdata[STAT_FULL_LSB + c]  = w_full[c];
         end
      end else if (ri_addr == REG_IRQ) begin
         w_rdata[IRQ_PEND_LSB +: NCH] = r_pend;
         w_rdata[IRQ_EN_LSB +: NCH]   = r_en;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ri_addr == ch_reg(c, OFF_ADDR))  w_rdata[AW-1:0] = r_addr[c];
            if (ri_addr == ch_reg(c, OFF_STEP))  w_rdata[AW-1:0] = r_step[c];
            if (ri_addr == ch_reg(c, OFF_LEVEL)) w_rdata[LW-1:0] = w_level[c];
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst)        to_cpu <= '0;
      else if (ri_en) to_cpu <= w_rdata;
   end
endmodule

// File: tb/tb_xgri_mc.sv
// Bench for xgri_mc: a queue-based register/FIFO model is compared against
// the outputs every cycle, with directed scenarios pinned by literal values.
module tb_xgri_mc;
   localparam int NCH = 2, DW = 16, DEPTH = 16, AW = 13;

   logic              clk_sys = 1'b0;
   logic              rst;
   logic              ri_en, ri_wren, ri_ren;
   logic [4:0]        ri_addr;
   logic [DW-1:0]     from_cpu;
   logic [DW-1:0]     to_cpu;
   logic [NCH-1:0]    ch_full;
   logic [NCH-1:0]    ch_pop;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH*AW-1:0] ch_addr;
   logic              irq;

   xgri_mc dut (
      .clk_sys (clk_sys), .rst (rst), .ri_en (ri_en), .ri_wren (ri_wren),
      .ri_ren (ri_ren), .ri_addr (ri_addr), .from_cpu (from_cpu),
      .to_cpu (to_cpu), .ch_full (ch_full), .ch_pop (ch_pop),
      .ch_data (ch_data), .ch_addr (ch_addr), .irq (irq)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   // reference model state
   logic [DW-1:0]  exp_q [NCH][$];
   logic [AW-1:0]  m_addr [NCH];
   logic [AW-1:0]  m_step [NCH];
   logic [NCH-1:0] m_pend, m_en, m_drn, m_w1c;
   logic [DW-1:0]  m_rd;
   bit             m_wr;
   bit             chk_on = 1'b0;
   int             n_chk = 0;
   int             n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input int a);
      logic [DW-1:0] v;
      v = '0;
      if (a == 0) begin
         for (int c = 0; c < NCH; c++) begin
            v[c]     = (exp_q[c].size() == 0);
            v[8 + c] = (exp_q[c].size() == DEPTH);
         end
      end else if (a == 1) begin
         for (int c = 0; c < NCH; c++) begin
            v[c]     = m_pend[c];
            v[8 + c] = m_en[c];
         end
      end else if (a >= 4 && (a - 4) / 4 < NCH) begin
         int c = (a - 4) / 4;
         case ((a - 4) % 4)
            0: v[AW-1:0] = m_addr[c];
            1: v[AW-1:0] = m_step[c];
            3: v = DW'(exp_q[c].size());
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   always @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            m_addr[c] = '0;
            m_step[c] = AW'(1);
         end
         m_pend = '0;
         m_en   = '0;
         m_rd   = '0;
      end else begin
         if (ri_en) m_rd = model_read(int'(ri_addr));
         m_wr  = ri_en && ri_wren;
         m_drn = '0;
         for (int c = 0; c < NCH; c++) begin
            bit push, pop, fl;
            int pre;
            push = m_wr && int'(ri_addr) == 4 + 4 * c + 2;
            fl   = m_wr && int'(ri_addr) == 2 && from_cpu[c];
            pre  = exp_q[c].size();
            pop  = ch_pop[c] && pre > 0;
            if (fl) exp_q[c].delete();
            else begin
               if (pop && pre == 1 && !push) m_drn[c] = 1'b1;
               if (pop) void'(exp_q[c].pop_front());
               if (push && (pre < DEPTH || pop)) exp_q[c].push_back(from_cpu);
            end
            if (m_wr && int'(ri_addr) == 4 + 4 * c) m_addr[c] = from_cpu[AW-1:0];
            else if (m_drn[c]) m_addr[c] = m_addr[c] + m_step[c];
            if (m_wr && int'(ri_addr) == 4 + 4 * c + 1) m_step[c] = from_cpu[AW-1:0];
         end
         m_w1c  = (m_wr && ri_addr == 5'd1) ? from_cpu[NCH-1:0] : '0;
         m_pend = (m_pend & ~m_w1c) | m_drn;
         if (m_wr && ri_addr == 5'd1) m_en = from_cpu[8 +: NCH];
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk_sys) begin
      if (chk_on && !rst) begin
         for (int c = 0; c < NCH; c++) begin
            chk("ch_full", 32'(ch_full[c]), 32'(exp_q[c].size() == DEPTH));
            if (exp_q[c].size() > 0) chk("ch_data", 32'(ch_data[c*DW +: DW]), 32'(exp_q[c][0]));
            chk("ch_addr", 32'(ch_addr[c*AW +: AW]), 32'(m_addr[c]));
         end
         chk("irq", 32'(irq), 32'(|(m_pend & m_en)));
         chk("to_cpu", 32'(to_cpu), 32'(m_rd));
      end
   end

   // driver tasks: every task starts and ends 1 time unit after a rising edge
   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle();
      ri_en = 0; ri_wren = 0; ri_ren = 0; ch_pop = '0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
      ri_en = 1; ri_wren = 1; ri_addr = a; from_cpu = d;
      cyc();
      idle();
   endtask

   task automatic rd_check(input logic [4:0] a, input logic [DW-1:0] exp, input string name);
      ri_en = 1; ri_ren = 1; ri_addr = a;
      cyc();
      idle();
      chk(name, 32'(to_cpu), 32'(exp));
   endtask

   task automatic pop(input logic [NCH-1:0] m);
      ch_pop = m;
      cyc();
      idle();
   endtask

   initial begin
      int p;
      rst = 1; idle(); ri_addr = '0; from_cpu = '0;
      repeat (3) @(posedge clk_sys);
      #1 rst = 0; chk_on = 1;

      // reset state
      chk("rst_to_cpu", 32'(to_cpu), 0);
      chk("rst_full", 32'(ch_full), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_addr", 32'(ch_addr), 0);
      rd_check(5'd0, 16'h0003, "rst_status");
      rd_check(5'd5, 16'h0001, "rst_step0");

      // ordered drain of channel 0 advances its address
      wr(5'd5, 16'd4);
      wr(5'd4, 16'h0100);
      wr(5'd6, 16'h00A1); wr(5'd6, 16'h00A2); wr(5'd6, 16'h00A3);
      chk("c0_head1", 32'(ch_data[15:0]), 32'h00A1); pop(2'b01);
      chk("c0_head2", 32'(ch_data[15:0]), 32'h00A2); pop(2'b01);
      chk("c0_head3", 32'(ch_data[15:0]), 32'h00A3); pop(2'b01);
      chk("c0_addr_step", 32'(ch_addr[12:0]), 32'h0104);
      rd_check(5'd1, 16'h0001, "c0_pending");
      wr(5'd1, 16'h0001);

      // channel 1 overflow
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) chk("c1_not_full", 32'(ch_full[1]), 0);
         wr(5'd10, 16'(16'h0200 + i));
      end
      chk("c1_full", 32'(ch_full[1]), 1);
      wr(5'd10, 16'h02FF);
      rd_check(5'd11, 16'(DEPTH), "c1_level");
      for (int i = 0; i < DEPTH; i++) begin
         chk("c1_order", 32'(ch_data[31:16]), 32'(16'h0200 + i));
         pop(2'b10);
      end
      rd_check(5'd0, 16'h0003, "c1_drained");
      wr(5'd1, 16'h0002);

      // interrupt, W1C, W1C racing a new drain
      wr(5'd1, 16'h0100);
      wr(5'd6, 16'h0011);
      pop(2'b01);
      chk("irq_set", 32'(irq), 1);
      wr(5'd1, 16'h0101);
      chk("irq_clr", 32'(irq), 0);
      wr(5'd6, 16'h0022);
      ri_en = 1; ri_wren = 1; ri_addr = 5'd1; from_cpu = 16'h0101; ch_pop = 2'b01;
      cyc(); idle();
      chk("irq_race", 32'(irq), 1);
      rd_check(5'd1, 16'h0101, "pend_race");
      wr(5'd1, 16'h0001);

      // flush
      for (int i = 0; i < 5; i++) wr(5'd6, 16'(16'h0300 + i));
      rd_check(5'd7, 16'd5, "c0_level5");
      wr(5'd2, 16'h0001);
      rd_check(5'd7, 16'd0, "flush_level");
      chk("flush_addr", 32'(ch_addr[12:0]), 32'h010C);
      rd_check(5'd1, 16'h0000, "flush_pend");

      // address wrap and CPU write racing a drain
      wr(5'd4, 16'h1FFE);
      wr(5'd6, 16'h0033);
      pop(2'b01);
      chk("addr_wrap", 32'(ch_addr[12:0]), 32'h0002);
      wr(5'd6, 16'h0044);
      ri_en = 1; ri_wren = 1; ri_addr = 5'd4; from_cpu = 16'h0055; ch_pop = 2'b01;
      cyc(); idle();
      chk("addr_cpu_win", 32'(ch_addr[12:0]), 32'h0055);
      rd_check(5'd1, 16'h0001, "pend_cpu_win");
      wr(5'd1, 16'h0001);

      // reset mid-burst
      for (int i = 0; i < 4; i++) wr(5'd10, 16'(16'h0400 + i));
      rd_check(5'd11, 16'd4, "c1_level4");
      rst = 1;
      #2;
      chk("mid_rst_to_cpu", 32'(to_cpu), 0);
      chk("mid_rst_full", 32'(ch_full), 0);
      chk("mid_rst_irq", 32'(irq), 0);
      chk("mid_rst_addr", 32'(ch_addr), 0);
      cyc();
      rst = 0;
      rd_check(5'd0, 16'h0003, "mid_rst_status");
      rd_check(5'd5, 16'h0001, "mid_rst_step");

      // randomized traffic, model-checked every cycle
      for (int n = 0; n < 3000; n++) begin
         int r;
         p = (n < 1500) ? 12 : 40;
         ri_en   = ($urandom_range(0, 99) < 60);
         ri_wren = 1'($urandom_range(0, 1));
         ri_ren  = ri_en && !ri_wren;
         r = $urandom_range(0, 9);
         if (r < 3)       ri_addr = 5'd6;
         else if (r < 5)  ri_addr = 5'd10;
         else if (r == 5) ri_addr = 5'd2;
         else             ri_addr = 5'($urandom_range(0, 31));
         from_cpu = 16'($urandom);
         for (int c = 0; c < NCH; c++) ch_pop[c] = ($urandom_range(0, 99) < p);
         cyc();
      end
      idle();
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
